// File: rtl/seven_seg_scan_mux_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: segment width,
// bit order and the glyph patterns used by the BCD decoder.
package seven_seg_scan_mux_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Bit position of each segment inside seg_t: a is the MSB, g the LSB.
  typedef enum int unsigned {
    SEG_IDX_G = 0,
    SEG_IDX_F = 1,
    SEG_IDX_E = 2,
    SEG_IDX_D = 3,
    SEG_IDX_C = 4,
    SEG_IDX_B = 5,
    SEG_IDX_A = 6
  } seg_idx_e;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// Display-side bundle: scan controls and BCD data in, segment/digit drives out.
interface seven_seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_scan_mux_pkg::*;

  logic                    i_en;
  logic                    i_blank;
  logic [4*NUM_DIGITS-1:0] i_bcd;
  logic [NUM_DIGITS-1:0]   i_dp;
  seg_t                    o_seg;
  logic                    o_dp;
  logic [NUM_DIGITS-1:0]   o_digit_sel;

  modport master (
    output i_en,
    output i_blank,
    output i_bcd,
    output i_dp,
    input  o_seg,
    input  o_dp,
    input  o_digit_sel
  );

  modport slave (
    input  i_en,
    input  i_blank,
    input  i_bcd,
    input  i_dp,
    output o_seg,
    output o_dp,
    output o_digit_sel
  );

endinterface

// File: rtl/seven_seg_scan_mux_bcd_to_7seg.sv
// Single-digit BCD to common-cathode segment decoder; codes 10-15 render dark.
module bcd_to_7seg
  import seven_seg_scan_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  // Glyph lookup for one BCD code
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment scanner with dead time between digits,
// frame-coherent snapshot of the BCD input and optional leading-zero blanking.
module seven_seg_scan_mux
  import seven_seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16,
  parameter int LZ_BLANK   = 1
)(
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  seven_seg_scan_mux_if.slave    bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int BW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]         D_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]         p_r;
  logic [PW-1:0]         p_nxt_s;
  logic [DW-1:0]         d_r;
  logic [DW-1:0]         d_nxt_s;
  logic [BW-1:0]         snap_bcd_r;
  logic [NUM_DIGITS-1:0] snap_dp_r;
  logic                  frame_start_s;
  logic [3:0]            cur_code_s;
  seg_t                  dec_seg_s;
  logic [NUM_DIGITS-1:0] zero_from_s;
  logic                  lz_hit_s;
  logic                  dark_s;
  seg_t                  seg_nxt_s;
  logic                  dp_nxt_s;
  logic [NUM_DIGITS-1:0] sel_nxt_s;
  seg_t                  seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] sel_r;

  // Prescaler and digit index next-state; both freeze while scanning is disabled
  always_comb begin
    p_nxt_s = p_r;
    d_nxt_s = d_r;
    if (bus.i_en) begin
      if (p_r == P_LAST) begin
        p_nxt_s = '0;
        if (d_r == D_LAST) begin
          d_nxt_s = '0;
        end else begin
          d_nxt_s = d_r + 1'b1;
        end
      end else begin
        p_nxt_s = p_r + 1'b1;
        d_nxt_s = d_r;
      end
    end else begin
      p_nxt_s = p_r;
      d_nxt_s = d_r;
    end
  end

  // Scan position registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      p_r <= '0;
      d_r <= '0;
    end else begin
      p_r <= p_nxt_s;
      d_r <= d_nxt_s;
    end
  end

  assign frame_start_s = bus.i_en && (p_r == '0) && (d_r == '0);

  // Frame snapshot: every digit of one frame comes from the same capture
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      snap_bcd_r <= '0;
      snap_dp_r  <= '0;
    end else if (frame_start_s) begin
      snap_bcd_r <= bus.i_bcd;
      snap_dp_r  <= bus.i_dp;
    end else begin
      snap_bcd_r <= snap_bcd_r;
      snap_dp_r  <= snap_dp_r;
    end
  end

  assign cur_code_s = snap_bcd_r[{d_r, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .bcd (cur_code_s),
    .seg (dec_seg_s)
  );

  // zero_from_s[k] is set when digits k..top are all code 0; invalid codes break the chain
  always_comb begin
    zero_from_s = '0;
    zero_from_s[NUM_DIGITS-1] = (snap_bcd_r[BW-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_from_s[k] = (snap_bcd_r[4*k +: 4] == 4'd0) && zero_from_s[k+1];
    end
  end

  assign lz_hit_s = (LZ_BLANK != 0) && (d_r != '0) && zero_from_s[d_r];
  assign dark_s   = !bus.i_en || bus.i_blank || (p_r == '0);

  // Next output values from the current scan position
  always_comb begin
    seg_nxt_s = SEG_BLANK;
    dp_nxt_s  = 1'b0;
    sel_nxt_s = '0;
    if (dark_s) begin
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b0;
      sel_nxt_s = '0;
    end else begin
      sel_nxt_s = SEL_ONE << d_r;
      dp_nxt_s  = snap_dp_r[d_r];
      seg_nxt_s = lz_hit_s ? SEG_BLANK : dec_seg_s;
    end
  end

  // Pin drive registers; reset darkens the display without waiting for a clock
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b0;
      sel_r <= '0;
    end else begin
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
      sel_r <= sel_nxt_s;
    end
  end

  assign bus.o_seg       = seg_r;
  assign bus.o_dp        = dp_r;
  assign bus.o_digit_sel = sel_r;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Scoreboard bench for seven_seg_scan_mux: a frame-time reference model queues
// the expected drive for every edge and an independent monitor compares it.
module tb_seven_seg_scan_mux;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int LZ    = 1;
  localparam int FRAME = N * SD;

  localparam logic [6:0] FONT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [3:0] SEL_SEQ [16] = '{
    4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2,
    4'd0, 4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd8, 4'd8
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        blank = 1'b0;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  dp = 4'h0;

  int errors = 0;
  int checks = 0;

  // reference model: t is the enabled-clock count within the frame
  int          t = 0;
  logic [15:0] m_bcd = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  resp_t       exp_q [$];

  seven_seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

  assign bus.i_en    = en;
  assign bus.i_blank = blank;
  assign bus.i_bcd   = bcd;
  assign bus.i_dp    = dp;

  seven_seg_scan_mux #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .LZ_BLANK   (LZ)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Predict the drive produced by the coming edge, then let the edge happen
  task automatic tick();
    resp_t       r;
    int          p;
    int          d;
    logic [15:0] upper;
    int          code;
    r = '0;
    if (!rst_n) begin
      t = 0;
      m_bcd = 16'h0;
      m_dp = 4'h0;
    end else begin
      p = t % SD;
      d = (t / SD) % N;
      if (en && !blank && p != 0) begin
        upper = m_bcd >> (4 * d);
        code  = int'(upper[3:0]);
        r.sel = 4'(1 << d);
        r.dp  = m_dp[d];
        r.seg = (code < 10) ? FONT[code] : 7'b0000000;
        if (LZ != 0 && d > 0 && upper == 16'h0) r.seg = 7'b0000000;
      end
      if (en && t == 0) begin
        m_bcd = bcd;
        m_dp  = dp;
      end
      if (en) t = (t + 1) % FRAME;
    end
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic goto_pos(input int target);
    for (int i = 0; i < 2 * FRAME && t != target; i++) tick();
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (bus.o_seg !== 7'b0 || bus.o_dp !== 1'b0 || bus.o_digit_sel !== 4'b0) begin
      errors++;
      $display("FAIL %s: got seg=%b dp=%b sel=%b, want all zero",
               name, bus.o_seg, bus.o_dp, bus.o_digit_sel);
    end
  endtask

  // Reset pulse between edges; outputs must clear before any clock edge
  task automatic async_reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    #2;
    rst_n = 1'b1;
    t = 0;
    m_bcd = 16'h0;
    m_dp = 4'h0;
  endtask

  // Monitor: one expected drive per edge, plus the one-hot property
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.o_seg, bus.o_dp, bus.o_digit_sel} !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got seg=%b dp=%b sel=%b, want seg=%b dp=%b sel=%b",
                   $time, bus.o_seg, bus.o_dp, bus.o_digit_sel, e.seg, e.dp, e.sel);
        end
        checks++;
        if ($countones(bus.o_digit_sel) > 1) begin
          errors++;
          $display("FAIL onehot @%0t: got sel=%b, want at most one bit", $time, bus.o_digit_sel);
        end
      end
    end
  end

  initial begin
    logic [15:0] v;
    int          nz;
    #1;
    check_dark("reset_state");
    run(2);
    #2;
    rst_n = 1'b1;
    bcd = 16'h1234;
    dp = 4'h0;

    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (bus.o_digit_sel !== SEL_SEQ[i]) begin
        errors++;
        $display("FAIL scan_seq[%0d]: got sel=%b, want sel=%b", i, bus.o_digit_sel, SEL_SEQ[i]);
      end
    end
    run(FRAME);

    bcd = 16'h0007; run(2 * FRAME);
    bcd = 16'h0000; run(2 * FRAME);
    bcd = 16'h0A05; run(2 * FRAME);

    bcd = 16'h1111; goto_pos(0); run(FRAME);
    goto_pos(2 * SD + 1);
    bcd = 16'h2222; run(2 * FRAME);

    bcd = 16'h1234; dp = 4'b0100; run(2 * FRAME);
    goto_pos(SD + 2);
    blank = 1'b1; run(10);
    blank = 1'b0; run(FRAME);

    goto_pos(SD + 2);
    en = 1'b0; run(20);
    en = 1'b1; run(FRAME);
    goto_pos(2 * SD + 2);
    async_reset_pulse();
    run(FRAME + 3);

    bcd = 16'hFEDC; dp = 4'b1010; run(2 * FRAME);

    for (int round = 0; round < 60; round++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
        else v[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      nz = $urandom_range(0, N);
      for (int k = N - nz; k < N; k++) v[4*k +: 4] = 4'h0;
      bcd = v;
      dp = 4'($urandom_range(0, 15));
      for (int i = 0; i < $urandom_range(4, 40); i++) begin
        en    = ($urandom_range(0, 9) != 0);
        blank = ($urandom_range(0, 9) == 0);
        tick();
      end
      if ($urandom_range(0, 9) == 0) async_reset_pulse();
    end
    en = 1'b1;
    blank = 1'b0;
    run(FRAME);

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
